// File: rtl/gt_arb_pkg.sv
// gt_arb_pkg: shared FSM encoding, default sizes and grant-counter limits for gt_share_arbiter
package gt_arb_pkg;
  typedef enum logic {IDLE = 1'b0, EVAL = 1'b1} state_t;
  localparam int DEF_NREQ = 4;
  localparam int DEF_W = 2;
  localparam int DEF_IDW = 2;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;
endpackage

// File: rtl/greater_than.sv
// greater_than: unsigned comparator, F = A > B (ports A, B in; F out)
module greater_than #(
  parameter int W = 2
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         F
);
  assign F = A > B;
endmodule

// File: rtl/gt_rr_pick.sv
// gt_rr_pick: combinational round-robin picker searching from ptr+1 with wrap (req, ptr in; win one-hot, idx out)
module gt_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] win,
  output logic [IDW-1:0]  idx
);
  logic found;
  logic [IDW-1:0] j;
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    j = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[j]) begin
        found = 1'b1;
        win[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/gt_share_arbiter.sv
// gt_share_arbiter: round-robin sharing of one greater_than among NREQ requesters (req/a_flat/b_flat in; gnt/busy/done/done_id/result out; grant_cnt with GT_ARB_STATS_EN)
module gt_share_arbiter
  import gt_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W = DEF_W,
  parameter int IDW = DEF_IDW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_flat,
  input  logic [NREQ*W-1:0] b_flat,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic              result
`ifdef GT_ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);
  state_t state, nxt;
  logic [W-1:0] op_a, op_b;
  logic [IDW-1:0] id_q, ptr, widx;
  logic [NREQ-1:0] win;
  logic take, f;
  gt_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req(req),
    .ptr(ptr),
    .win(win),
    .idx(widx)
  );
  greater_than #(.W(W)) u_gt (
    .A(op_a),
    .B(op_b),
    .F(f)
  );
  assign busy = state == EVAL;
  always_comb begin
    take = state == IDLE && |req;
    nxt = take ? EVAL : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      done <= 1'b0;
      done_id <= '0;
      result <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      id_q <= '0;
      ptr <= IDW'(NREQ - 1);
    end else begin
      state <= nxt;
      gnt <= take ? win : '0;
      done <= state == EVAL;
      if (take) begin
        op_a <= a_flat[widx*W +: W];
        op_b <= b_flat[widx*W +: W];
        id_q <= widx;
        ptr <= widx;
      end
      if (state == EVAL) begin
        result <= f;
        done_id <= id_q;
      end
    end
  end
`ifdef GT_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) grant_cnt <= '0;
    else
      for (int k = 0; k < NREQ; k++)
        if (take && win[k] && grant_cnt[k*CNT_W +: CNT_W] != CNT_MAX)
          grant_cnt[k*CNT_W +: CNT_W] <= grant_cnt[k*CNT_W +: CNT_W] + 1'b1;
  end
`endif
endmodule
